// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the 4-bit-opcode core: owns PC and IR,
// drives the instruction-fetch handshake and decodes register-file/ALU controls.
//
// state    | meaning
// IDLE     | waiting for run
// FETCH    | imem_req held at pc until imem_ack, IR loaded on ack
// DECODE   | route by opcode: ALU op, beq or illegal
// EXEC     | ALU operation in flight
// WB       | reg_we/retired pulse, pc advances
// BRANCH   | beq resolved from alu_zero, retired pulse, pc advances or jumps
// TRAP     | illegal opcode seen; frozen until reset
module multicycle_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    input  logic               alu_zero,
    output logic               reg_we,
    output logic               alu_src,
    output logic [1:0]         alu_ctrl,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               retired,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    br_off;
    logic [INSTR_W-1:0] ir_nxt;
    logic               illegal_nxt;
    logic [3:0]         opcode;
    logic [3:0]         imm4;

    assign opcode    = instr[INSTR_W-1 -: 4];
    assign imm4      = instr[3:0];
    assign pc_inc    = pc + PC_W'(1);
    assign br_off    = {{(PC_W-4){imm4[3]}}, imm4};
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            instr   <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr   <= ir_nxt;
            illegal <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = instr;
        illegal_nxt = illegal;
        imem_req    = 1'b0;
        reg_we      = 1'b0;
        retired     = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode <= 4'd6) begin
                    state_nxt = S_EXEC;
                end else if (opcode == 4'd7) begin
                    state_nxt = S_BRANCH;
                end else begin
                    state_nxt   = S_TRAP;
                    illegal_nxt = 1'b1;
                end
            end
            S_EXEC: state_nxt = S_WB;
            S_WB: begin
                reg_we    = 1'b1;
                retired   = 1'b1;
                pc_nxt    = pc_inc;
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_BRANCH: begin
                retired   = 1'b1;
                // taken target is relative to the following instruction
                pc_nxt    = alu_zero ? pc_inc + br_off : pc_inc;
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: busy = 1'b0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_src  = 1'b0;
        alu_ctrl = 2'b00;
        case (opcode)
            4'd0: alu_ctrl = 2'b00;
            4'd1: alu_ctrl = 2'b01;
            4'd2: alu_ctrl = 2'b10;
            4'd3: alu_ctrl = 2'b11;
            4'd4: begin alu_src = 1'b1; alu_ctrl = 2'b00; end
            4'd5: begin alu_src = 1'b1; alu_ctrl = 2'b01; end
            4'd6: begin alu_src = 1'b1; alu_ctrl = 2'b10; end
            4'd7: alu_ctrl = 2'b11;
            default: begin alu_src = 1'b0; alu_ctrl = 2'b00; end
        endcase
    end

endmodule
